// File: rtl/mbf_decim_fifo_if.sv
// mbf_decim_fifo_if: sample input, FIFO output and status signals of the MBF decimating FIFO.
interface mbf_decim_fifo_if #(parameter int AW = 3);
  logic in_valid;
  logic [12:0] x_in;
  logic [12:0] y_in;
  logic out_ready;
  logic out_valid;
  logic [25:0] out_data;
  logic [AW:0] level;
  logic overflow;
  logic burst_done;
  modport master (
    output in_valid, x_in, y_in, out_ready,
    input out_valid, out_data, level, overflow, burst_done
  );
  modport slave (
    input in_valid, x_in, y_in, out_ready,
    output out_valid, out_data, level, overflow, burst_done
  );
endinterface

// File: rtl/mbf_decim_fifo.sv
// mbf_decim_fifo: decimates MBF X/Y bursts into a FWFT FIFO with overflow and end-of-burst reporting.
module mbf_decim_fifo #(
  parameter int DECIM = 2,
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input logic CLK,
  input logic RESET,
  mbf_decim_fifo_if.slave bus
);
  localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [PW-1:0] phase;
  logic [25:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] level;
  logic overflow, valid, retained, full, push, pop, drained;
  assign retained = bus.in_valid && phase == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign valid = level != '0;
  assign pop = valid && bus.out_ready;
  assign push = retained && (!full || pop);
  assign drained = level == '0 || (level == (AW+1)'(1) && pop);
  assign bus.out_valid = valid;
  assign bus.out_data = valid ? mem[rp] : '0;
  assign bus.level = level;
  assign bus.overflow = overflow;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase <= '0;
      wp <= '0;
      rp <= '0;
      level <= '0;
      overflow <= 1'b0;
      state <= IDLE;
    end else begin
      phase <= (!bus.in_valid || phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      if (retained && full && !pop) overflow <= 1'b1;
      state <= nxt;
    end
  end
  // The array carries no reset: stale words are unreachable once level is zero.
  always_ff @(posedge CLK) begin
    if (push) mem[wp] <= {bus.x_in, bus.y_in};
  end
  always_comb begin
    nxt = bus.in_valid ? RUN : state == RUN ? DRAIN : state == DRAIN ? (drained ? DONE : DRAIN) : IDLE;
    bus.burst_done = state == DONE;
  end
endmodule

// File: tb/tb_mbf_decim_fifo.sv
// tb_mbf_decim_fifo: randomized and directed checks of DECIM=2 and DECIM=1 instances against a queue model.
module tb_mbf_decim_fifo;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_DONE = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic iv = 1'b0;
  logic rdy = 1'b0;
  logic [12:0] xi = '0;
  logic [12:0] yi = '0;
  int vecs = 0;
  int errs = 0;
  logic [25:0] mq [2][$];
  int run [2];
  bit movf [2];
  int mst [2];
  logic [25:0] got [$];
  mbf_decim_fifo_if #(.AW(3)) b2 ();
  mbf_decim_fifo_if #(.AW(3)) b1 ();
  assign b2.in_valid = iv;
  assign b2.x_in = xi;
  assign b2.y_in = yi;
  assign b2.out_ready = rdy;
  assign b1.in_valid = iv;
  assign b1.x_in = xi;
  assign b1.y_in = yi;
  assign b1.out_ready = rdy;
  mbf_decim_fifo #(.DECIM(2), .DEPTH(8), .AW(3)) u2 (.CLK(clk), .RESET(reset), .bus(b2));
  mbf_decim_fifo #(.DECIM(1), .DEPTH(8), .AW(3)) u1 (.CLK(clk), .RESET(reset), .bus(b1));
  always #5 clk = ~clk;

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int d, sz, nst;
      bit pop, ret, drained;
      d = k ? 1 : 2;
      if (reset) begin
        mq[k].delete();
        run[k] = 0;
        movf[k] = 0;
        mst[k] = S_IDLE;
      end else begin
        sz = mq[k].size();
        pop = sz != 0 && rdy;
        ret = iv && (run[k] % d == 0);
        drained = sz == 0 || (sz == 1 && pop);
        case (mst[k])
          S_IDLE: nst = iv ? S_RUN : S_IDLE;
          S_RUN: nst = iv ? S_RUN : S_DRAIN;
          S_DRAIN: nst = iv ? S_RUN : drained ? S_DONE : S_DRAIN;
          default: nst = iv ? S_RUN : S_IDLE;
        endcase
        mst[k] = nst;
        if (pop) void'(mq[k].pop_front());
        if (ret) begin
          if (sz < 8 || pop) mq[k].push_back({xi, yi});
          else movf[k] = 1;
        end
        run[k] = iv ? run[k] + 1 : 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [32:0] exp_vec(int k);
    int sz;
    sz = mq[k].size();
    return {sz != 0, sz != 0 ? mq[k][0] : 26'd0, 4'(sz), movf[k], mst[k] == S_DONE};
  endfunction

  function automatic logic [32:0] act_vec(int k);
    return k ? {b1.out_valid, b1.out_data, b1.level, b1.overflow, b1.burst_done}
             : {b2.out_valid, b2.out_data, b2.level, b2.overflow, b2.burst_done};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    iv = 1'b0;
    rdy = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (act_vec(k) !== 33'd0) begin
        errs++;
        $display("FAIL reset decim%0d got %h want 0", 2 - k, act_vec(k));
      end
    end
  endtask

  task automatic test_burst();
    int done_cnt;
    do_reset();
    got.delete();
    done_cnt = 0;
    for (int i = 1; i <= 18; i++) begin
      iv = i <= 10;
      xi = 13'(i);
      yi = 13'(100 + i);
      rdy = 1'b1;
      if (b2.out_valid && rdy) got.push_back(b2.out_data);
      cycle();
      if (b2.burst_done) done_cnt++;
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (act_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL burst decim%0d cyc%0d got %h want %h", 2 - k, i, act_vec(k), exp_vec(k));
        end
      end
    end
    vecs++;
    if (got.size() != 5) begin
      errs++;
      $display("FAIL burst_count got %0d want 5", got.size());
    end
    for (int j = 0; j < got.size() && j < 5; j++) begin
      vecs++;
      if (got[j] !== {13'(2 * j + 1), 13'(101 + 2 * j)}) begin
        errs++;
        $display("FAIL burst_word%0d got %h want %h", j, got[j], {13'(2 * j + 1), 13'(101 + 2 * j)});
      end
    end
    vecs++;
    if (done_cnt != 1 || b2.overflow !== 1'b0) begin
      errs++;
      $display("FAIL burst_done pulses %0d ovf %b want 1 0", done_cnt, b2.overflow);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    got.delete();
    for (int i = 1; i <= 20; i++) begin
      iv = 1'b1;
      rdy = 1'b0;
      xi = 13'(i);
      yi = 13'(200 + i);
      cycle();
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (act_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL overflow decim%0d cyc%0d got %h want %h", 2 - k, i, act_vec(k), exp_vec(k));
        end
      end
    end
    vecs++;
    if (b2.level !== 4'd8 || b2.overflow !== 1'b1) begin
      errs++;
      $display("FAIL ovf_full level %0d ovf %b want 8 1", b2.level, b2.overflow);
    end
    for (int i = 0; i < 12; i++) begin
      iv = 1'b0;
      rdy = 1'b1;
      if (b2.out_valid) got.push_back(b2.out_data);
      cycle();
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (act_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL ovf_drain decim%0d got %h want %h", 2 - k, act_vec(k), exp_vec(k));
        end
      end
    end
    vecs++;
    if (got.size() != 8) begin
      errs++;
      $display("FAIL ovf_count got %0d want 8", got.size());
    end
    for (int j = 0; j < got.size() && j < 8; j++) begin
      vecs++;
      if (got[j] !== {13'(2 * j + 1), 13'(201 + 2 * j)}) begin
        errs++;
        $display("FAIL ovf_word%0d got %h want %h", j, got[j], {13'(2 * j + 1), 13'(201 + 2 * j)});
      end
    end
  endtask

  task automatic test_full_pop();
    logic [25:0] w [$];
    do_reset();
    for (int i = 0; i < 16; i++) begin
      iv = 1'b1;
      rdy = 1'b0;
      xi = 13'($urandom);
      yi = 13'($urandom);
      if (i % 2 == 0) w.push_back({xi, yi});
      cycle();
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (act_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL fill decim%0d got %h want %h", 2 - k, act_vec(k), exp_vec(k));
        end
      end
    end
    rdy = 1'b1;
    xi = 13'($urandom);
    yi = 13'($urandom);
    cycle();
    vecs++;
    if (b2.level !== 4'd8 || b2.overflow !== 1'b0 || b2.out_data !== w[1]) begin
      errs++;
      $display("FAIL full_pop level %0d ovf %b head %h want 8 0 %h", b2.level, b2.overflow, b2.out_data, w[1]);
    end
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (act_vec(k) !== exp_vec(k)) begin
        errs++;
        $display("FAIL full_pop_model decim%0d got %h want %h", 2 - k, act_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_gap();
    int done_early, done_cnt;
    logic [5:0] pat;
    int xs [6];
    pat = 6'b110111;
    xs = '{1, 2, 3, 0, 4, 5};
    do_reset();
    got.delete();
    done_early = 0;
    done_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      iv = i < 6 ? pat[i] : 1'b0;
      xi = i < 6 ? 13'(xs[i]) : 13'd0;
      yi = xi + 13'd100;
      rdy = 1'b1;
      if (b2.out_valid) got.push_back(b2.out_data);
      cycle();
      if (b2.burst_done) begin
        done_cnt++;
        if (i < 6) done_early++;
      end
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (act_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL gap decim%0d cyc%0d got %h want %h", 2 - k, i, act_vec(k), exp_vec(k));
        end
      end
    end
    vecs++;
    if (got.size() != 3 || got[0] !== {13'd1, 13'd101} || got[1] !== {13'd3, 13'd103} || got[2] !== {13'd4, 13'd104}) begin
      errs++;
      $display("FAIL gap_words got %0d words first %h want 3 words 1,3,4", got.size(), got.size() ? got[0] : 26'd0);
    end
    vecs++;
    if (done_early != 0 || done_cnt != 1) begin
      errs++;
      $display("FAIL gap_done early %0d total %0d want 0 1", done_early, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      iv = 1'b1;
      rdy = 1'b0;
      xi = 13'($urandom);
      yi = 13'($urandom);
      cycle();
    end
    vecs++;
    if (b2.level !== 4'd5) begin
      errs++;
      $display("FAIL mid_level got %0d want 5", b2.level);
    end
    reset = 1'b1;
    cycle();
    vecs++;
    if ({b2.out_valid, b2.level, b2.overflow, b2.burst_done} !== 7'd0) begin
      errs++;
      $display("FAIL mid_reset got v%b l%0d o%b d%b want 0", b2.out_valid, b2.level, b2.overflow, b2.burst_done);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iv = i < 3;
      xi = 13'(50 + i);
      yi = 13'(150 + i);
      cycle();
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (act_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL mid_next decim%0d got %h want %h", 2 - k, act_vec(k), exp_vec(k));
        end
      end
    end
    vecs++;
    if (b2.level !== 4'd2 || b2.out_data !== {13'd50, 13'd150}) begin
      errs++;
      $display("FAIL mid_fresh level %0d head %h want 2 %h", b2.level, b2.out_data, {13'd50, 13'd150});
    end
  endtask

  task automatic test_decim1();
    logic [25:0] sent [$];
    logic [25:0] prev;
    bit hold;
    do_reset();
    got.delete();
    for (int i = 0; i < 26; i++) begin
      iv = i < 12;
      rdy = i < 12 ? (i % 2 == 0) : 1'b1;
      xi = 13'($urandom);
      yi = 13'($urandom);
      if (iv) sent.push_back({xi, yi});
      if (b1.out_valid && rdy) got.push_back(b1.out_data);
      hold = b1.out_valid && !rdy;
      prev = b1.out_data;
      cycle();
      if (hold) begin
        vecs++;
        if (b1.out_data !== prev) begin
          errs++;
          $display("FAIL d1_stable cyc%0d got %h want %h", i, b1.out_data, prev);
        end
      end
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (act_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL d1 decim%0d cyc%0d got %h want %h", 2 - k, i, act_vec(k), exp_vec(k));
        end
      end
    end
    vecs++;
    if (got != sent || b1.overflow !== 1'b0) begin
      errs++;
      $display("FAIL d1_order got %0d words ovf %b want %0d words ovf 0", got.size(), b1.overflow, sent.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset = $urandom_range(0, 99) == 0;
      iv = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 2) != 0;
      xi = 13'($urandom);
      yi = 13'($urandom);
      cycle();
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (act_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL random decim%0d cyc%0d got %h want %h", 2 - k, i, act_vec(k), exp_vec(k));
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_overflow();
    test_full_pop();
    test_gap();
    test_reset_mid();
    test_decim1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mbf_decim_fifo.md
Name: mbf_decim_fifo

Overview:
- Stage directly downstream of the multi-bank filter (MBF).
- Consumes the filter's high-pass (X) and low-pass (Y) 13-bit outputs under its valid strobe.
- Decimates each burst by DECIM, packs each retained X/Y pair into one 26-bit word, and buffers it in a first-word-fall-through FIFO.
- Presents FIFO words on a valid/ready interface and reports overflow and end-of-burst.

Parameters:
- DECIM, 2: decimation factor. Keep 1 of every DECIM valid samples; legal range 1..8.
- DEPTH, 8: FIFO depth in words; power of two, 2..64.
- AW, 3: log2(DEPTH).

Ports:
- CLK  input  1  single clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- IN_VALID  input  1  sample strobe; driven by the filter's OUT_VALID.
- X_IN  input  13  high-pass sample; driven by the filter's X_DATA.
- Y_IN  input  13  low-pass sample; driven by the filter's Y_DATA.
- OUT_READY  input  1  downstream ready.
- OUT_VALID  output  1  OUT_DATA holds a valid word.
- OUT_DATA  output  26  {X, Y}; X in [25:13], Y in [12:0].
- LEVEL  output  AW+1  current FIFO occupancy, 0..DEPTH.
- OVERFLOW  output  1  sticky flag: a retained sample was dropped.
- BURST_DONE  output  1  one-cycle pulse: burst ended and FIFO fully drained.

Behaviour:
- Reset is synchronous: sampled only on the CLK rising edge while RESET=1. RESET dominates every other input.
  - All outputs go to 0, the FIFO is emptied, phase = 0, and the FSM returns to IDLE.
  - Reset mid-burst discards all buffered words; they are not output.
- Decimation phase counter (width ceil(log2(DECIM)), minimum 1 bit):
  - Increments on each cycle with IN_VALID=1 and wraps from DECIM-1 to 0.
  - Cleared on any cycle with IN_VALID=0, so every burst starts at phase 0.
  - A sample is retained when IN_VALID=1 and phase==0.
  - DECIM=1 retains every sample.
- Push and pop:
  - push = retained & (!full | pop).
  - pop = OUT_VALID & OUT_READY.
  - Push and pop in the same cycle are both allowed, including when full (LEVEL unchanged) and when empty with a push (no bypass: the pop cannot occur while empty).
- Latency: a retained sample captured at edge t is visible on OUT_DATA with OUT_VALID=1 from edge t+1 when the FIFO was empty.
- FWFT: OUT_VALID = (LEVEL != 0). OUT_DATA is the head word, registered from the array and stable while OUT_READY=0.
- Overflow: a retained sample arriving while full without a simultaneous pop is dropped and OVERFLOW is set at the next edge. OVERFLOW clears only on RESET.
- Pointers: read and write pointers are AW bits and wrap modulo DEPTH. LEVEL is a separate counter, saturating-free by construction.
- FSM states:
  - IDLE: IN_VALID=1 -> RUN.
  - RUN: IN_VALID=0 -> DRAIN.
  - DRAIN:
    - IN_VALID=1 -> RUN (new burst; phase already 0).
    - else LEVEL==0, or LEVEL==1 & pop -> DONE.
  - DONE: BURST_DONE=1 for this one cycle. Then IN_VALID=1 -> RUN, else -> IDLE.
  - A burst with zero retained samples still produces DONE.
- X and Y are not modified: no rounding and no sign handling (the upstream filter already rounded).

Test Plan:
- RESET for 2 cycles, then 10 consecutive IN_VALID samples X=1..10, Y=101..110, OUT_READY=1, DECIM=2 -> OUT_DATA pairs (1,101), (3,103), (5,105), (7,107), (9,109), each 1 cycle after capture; BURST_DONE pulses once after the last pop; OVERFLOW=0.
- OUT_READY=0, 20 valid samples, DECIM=2, DEPTH=8 -> LEVEL reaches 8; samples 17 and 19 are dropped; OVERFLOW=1 from the cycle after sample 17; after OUT_READY=1, exactly 8 words (1..15, odd) are output in order.
- FIFO full, retained sample arrives with OUT_READY=1 -> head pops and the new word is written; LEVEL stays 8; OVERFLOW stays 0.
- IN_VALID pattern 1,1,1,0,1,1 with X=1,2,3,-,4,5, DECIM=2 -> retained 1, 3, 4 (phase cleared by the gap); FSM path RUN->DRAIN->RUN with no BURST_DONE until the final drain.
- RESET asserted with LEVEL=5 mid-burst -> next cycle OUT_VALID=0, LEVEL=0, OVERFLOW=0, BURST_DONE=0; the next burst starts fresh at phase 0.
- DECIM=1, OUT_READY toggling 1,0,1,0 with 12 continuous samples -> no loss while LEVEL<8; output order equals input order; OUT_DATA stable on every OUT_READY=0 cycle.
